// File: rtl/mem_port_arbiter_if.sv
// Signal bundle linking both requesters and the memory macro to mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1,
        output rdata, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1,
        input  rdata, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU path (port 0)
// and the loader/debug port (port 1); one access in flight, fixed read latency.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input logic          CLK,
    input logic          CLB,
    mem_port_arbiter_if.slave bus
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : gBadLatency
        $error("mem_port_arbiter: MEM_LAT must be within 1..7");
    end

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } stateT;

    stateT             state;
    logic              lastGnt;
    logic              owner;
    logic [2:0]        latCnt;

    logic              winner;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        winner = bus.req1;
        if (bus.req0 && bus.req1) winner = ~lastGnt;
        selWe    = winner ? bus.we1    : bus.we0;
        selAddr  = winner ? bus.addr1  : bus.addr0;
        selWdata = winner ? bus.wdata1 : bus.wdata0;
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state         <= IDLE;
            lastGnt       <= 1'b1;
            owner         <= 1'b0;
            latCnt        <= 3'd0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state         <= ISSUE;
                        bus.busy      <= 1'b1;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= selWe;
                        bus.mem_addr  <= selAddr;
                        bus.mem_wdata <= selWdata;
                        bus.gnt0      <= ~winner;
                        bus.gnt1      <= winner;
                        lastGnt       <= winner;
                        owner         <= winner;
                    end
                end

                ISSUE: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    bus.gnt0   <= 1'b0;
                    bus.gnt1   <= 1'b0;
                    if (bus.mem_we) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state       <= WAIT;
                        latCnt      <= LAT;
                        // With a one-cycle memory the data is already due in the first WAIT cycle.
                        bus.rvalid0 <= (LAT == 3'd1) && !owner;
                        bus.rvalid1 <= (LAT == 3'd1) && owner;
                    end
                end

                WAIT: begin
                    latCnt <= latCnt - 3'd1;
                    if (latCnt == 3'd1) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.rvalid0 <= 1'b0;
                        bus.rvalid1 <= 1'b0;
                    end else begin
                        bus.rvalid0 <= (latCnt == 3'd2) && !owner;
                        bus.rvalid1 <= (latCnt == 3'd2) && owner;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata = (bus.rvalid0 || bus.rvalid1) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with MEM_LAT=3, one with MEM_LAT=1,
// each backed by a latency-accurate read-only memory model.
module tb_mem_port_arbiter;

    typedef struct {
        int         cyc;
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int         cyc;
        logic       port;
        logic [7:0] data;
    } rd_exp_t;

    logic CLK = 1'b0;
    logic CLB;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    gnt_exp_t gq3[$];
    gnt_exp_t gq1[$];
    rd_exp_t  rq3[$];
    rd_exp_t  rq1[$];

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) i3 ();
    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) i1 ();

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) dut3 (
        .CLK(CLK), .CLB(CLB), .bus(i3.slave)
    );
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut1 (
        .CLK(CLK), .CLB(CLB), .bus(i1.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory contents as the bench expects them; data appears MEM_LAT cycles after mem_en.
    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'h10:   rom = 8'hA7;
            8'h22:   rom = 8'h3C;
            default: rom = a ^ 8'h5A;
        endcase
    endfunction

    logic [2:0] p3v;
    logic [7:0] p3d [3];
    logic       p1v;
    logic [7:0] p1d;

    always @(posedge CLK) begin
        p3v    <= {p3v[1:0], i3.mem_en && !i3.mem_we};
        p3d[0] <= rom(i3.mem_addr);
        p3d[1] <= p3d[0];
        p3d[2] <= p3d[1];
        p1v    <= i1.mem_en && !i1.mem_we;
        p1d    <= rom(i1.mem_addr);
    end

    assign i3.mem_rdata = p3v[2] ? p3d[2] : 8'hEE;
    assign i1.mem_rdata = p1v    ? p1d    : 8'hEE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void exp_gnt(input int d, input int c, input logic p, input logic we,
                                    input logic [7:0] a, input logic [7:0] wd);
        gnt_exp_t e;
        e.cyc = c; e.port = p; e.we = we; e.addr = a; e.wdata = wd;
        if (d == 3) gq3.push_back(e);
        else        gq1.push_back(e);
    endfunction

    function automatic void exp_rd(input int d, input int c, input logic p, input logic [7:0] data);
        rd_exp_t e;
        e.cyc = c; e.port = p; e.data = data;
        if (d == 3) rq3.push_back(e);
        else        rq1.push_back(e);
    endfunction

    task automatic mon(input int d, input logic g0, input logic g1, input logic r0, input logic r1,
                       input logic en, input logic mwe, input logic [7:0] ma, input logic [7:0] mwd,
                       input logic [7:0] rd);
        gnt_exp_t ge;
        rd_exp_t  re;
        bit       have;
        if (g0 || g1) begin
            have = (d == 3) ? (gq3.size() > 0) : (gq1.size() > 0);
            if (!have) begin
                check($sformatf("dut%0d_unexpected_gnt", d), {62'd0, g0, g1}, 64'd0);
            end else begin
                ge = (d == 3) ? gq3.pop_front() : gq1.pop_front();
                check($sformatf("dut%0d_gnt{cyc,port,both,en,we,addr,wdata}", d),
                      {cyc, g1, g0 & g1, en, mwe, ma, mwd},
                      {ge.cyc, ge.port, 1'b0, 1'b1, ge.we, ge.addr, ge.wdata});
            end
        end else if (en) begin
            check($sformatf("dut%0d_mem_en_without_gnt", d), {63'd0, en}, 64'd0);
        end
        if (r0 || r1) begin
            have = (d == 3) ? (rq3.size() > 0) : (rq1.size() > 0);
            if (!have) begin
                check($sformatf("dut%0d_unexpected_rvalid", d), {62'd0, r0, r1}, 64'd0);
            end else begin
                re = (d == 3) ? rq3.pop_front() : rq1.pop_front();
                check($sformatf("dut%0d_rvalid{cyc,port,both,rdata}", d),
                      {cyc, r1, r0 & r1, rd}, {re.cyc, re.port, 1'b0, re.data});
            end
        end else if (rd != 8'h00) begin
            check($sformatf("dut%0d_rdata_gated", d), {56'd0, rd}, 64'd0);
        end
    endtask

    always @(negedge CLK) begin
        mon(3, i3.gnt0, i3.gnt1, i3.rvalid0, i3.rvalid1, i3.mem_en, i3.mem_we,
            i3.mem_addr, i3.mem_wdata, i3.rdata);
        mon(1, i1.gnt0, i1.gnt1, i1.rvalid0, i1.rvalid1, i1.mem_en, i1.mem_we,
            i1.mem_addr, i1.mem_wdata, i1.rdata);
    end

    task automatic wait_gnt3(input logic p, input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(p ? i3.gnt1 : i3.gnt0) && n < 20);
        check(name, {63'd0, (p ? i3.gnt1 : i3.gnt0)}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        CLB = 1'b0;
        {i1.req0, i1.we0, i1.addr0, i1.wdata0} = '0;
        {i1.req1, i1.we1, i1.addr1, i1.wdata1} = '0;
        {i3.req0, i3.we0, i3.addr0, i3.wdata0} = {1'b1, 1'b1, 8'h3A, 8'h5C};
        {i3.req1, i3.we1, i3.addr1, i3.wdata1} = {1'b1, 1'b1, 8'h11, 8'h77};

        // Reset held with both requests pending: everything quiet.
        repeat (3) @(negedge CLK);
        check("reset_outputs_dut3",
              {33'd0, i3.gnt0, i3.gnt1, i3.rvalid0, i3.rvalid1, i3.busy, i3.mem_en, i3.mem_we,
               i3.mem_addr, i3.mem_wdata, i3.rdata}, 64'd0);
        check("reset_outputs_dut1",
              {33'd0, i1.gnt0, i1.gnt1, i1.rvalid0, i1.rvalid1, i1.busy, i1.mem_en, i1.mem_we,
               i1.mem_addr, i1.mem_wdata, i1.rdata}, 64'd0);

        // Release: port 0 wins the first tie, its write issues in cycle 1, port 1 follows in cycle 3.
        exp_gnt(3, cyc + 1, 1'b0, 1'b1, 8'h3A, 8'h5C);
        exp_gnt(3, cyc + 3, 1'b1, 1'b1, 8'h11, 8'h77);
        CLB = 1'b1;
        wait_gnt3(1'b0, "first_gnt_port0");
        i3.req0 = 1'b0;
        @(negedge CLK);
        check("busy_low_after_write", {63'd0, i3.busy}, 64'd0);
        wait_gnt3(1'b1, "second_gnt_port1");
        i3.req1 = 1'b0;
        repeat (2) @(negedge CLK);

        // Port 1 read of 8'h10 on both latencies.
        {i3.we1, i3.addr1, i3.wdata1} = {1'b0, 8'h10, 8'h00};
        {i1.we1, i1.addr1, i1.wdata1} = {1'b0, 8'h10, 8'h00};
        exp_gnt(3, cyc + 1, 1'b1, 1'b0, 8'h10, 8'h00);
        exp_rd (3, cyc + 4, 1'b1, 8'hA7);
        exp_gnt(1, cyc + 1, 1'b1, 1'b0, 8'h10, 8'h00);
        exp_rd (1, cyc + 2, 1'b1, 8'hA7);
        i3.req1 = 1'b1;
        i1.req1 = 1'b1;
        wait_gnt3(1'b1, "read_gnt_port1");
        i3.req1 = 1'b0;
        i1.req1 = 1'b0;
        repeat (6) @(negedge CLK);

        // Both ports hold write requests: strict 0,1,0,1 at issue cycles 1,3,5,7.
        {i3.we0, i3.addr0, i3.wdata0} = {1'b1, 8'h40, 8'h01};
        {i3.we1, i3.addr1, i3.wdata1} = {1'b1, 8'h41, 8'h02};
        for (int k = 0; k < 4; k++) begin
            exp_gnt(3, cyc + 1 + 2 * k, 1'(k % 2), 1'b1, (k % 2) ? 8'h41 : 8'h40,
                    (k % 2) ? 8'h02 : 8'h01);
        end
        i3.req0 = 1'b1;
        i3.req1 = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge CLK);
            if (i3.gnt0 || i3.gnt1) n++;
        end
        i3.req0 = 1'b0;
        i3.req1 = 1'b0;
        check("contention_grant_count", 64'(n), 64'd4);
        repeat (3) @(negedge CLK);

        // Port 1 pulses during port 0's read wait and leaves before IDLE: ignored.
        {i3.we0, i3.addr0, i3.wdata0} = {1'b0, 8'h10, 8'h00};
        exp_gnt(3, cyc + 1, 1'b0, 1'b0, 8'h10, 8'h00);
        exp_rd (3, cyc + 4, 1'b0, 8'hA7);
        i3.req0 = 1'b1;
        wait_gnt3(1'b0, "read_gnt_port0");
        i3.req0 = 1'b0;
        {i3.req1, i3.we1, i3.addr1, i3.wdata1} = {1'b1, 1'b1, 8'h55, 8'h66};
        repeat (2) @(negedge CLK);
        i3.req1 = 1'b0;
        repeat (4) @(negedge CLK);

        // Port 0 request withdrawn before any edge samples it.
        seen = 1'b0;
        i3.req0 = 1'b1;
        #2;
        i3.req0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            seen |= i3.mem_en | i3.gnt0 | i3.gnt1;
        end
        check("withdrawn_req_no_access", {63'd0, seen}, 64'd0);

        // Reset in the first WAIT cycle of a read abandons it.
        {i3.we1, i3.addr1, i3.wdata1} = {1'b0, 8'h22, 8'h00};
        exp_gnt(3, cyc + 1, 1'b1, 1'b0, 8'h22, 8'h00);
        i3.req1 = 1'b1;
        wait_gnt3(1'b1, "midreset_read_gnt");
        i3.req1 = 1'b0;
        @(negedge CLK);
        CLB = 1'b0;
        #1;
        seen = i3.mem_en | i3.busy | i3.rvalid0 | i3.rvalid1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            seen |= i3.mem_en | i3.busy | i3.rvalid0 | i3.rvalid1 | (i3.rdata != 8'h00);
        end
        check("midreset_quiet", {63'd0, seen}, 64'd0);
        CLB = 1'b1;
        @(negedge CLK);

        // Fresh read after reset completes with the normal latency.
        exp_gnt(3, cyc + 1, 1'b1, 1'b0, 8'h22, 8'h00);
        exp_rd (3, cyc + 4, 1'b1, 8'h3C);
        i3.req1 = 1'b1;
        wait_gnt3(1'b1, "post_reset_read_gnt");
        i3.req1 = 1'b0;
        repeat (6) @(negedge CLK);

        check("dut3_gnt_queue_drained", 64'(gq3.size()), 64'd0);
        check("dut3_rd_queue_drained",  64'(rq3.size()), 64'd0);
        check("dut1_gnt_queue_drained", 64'(gq1.size()), 64'd0);
        check("dut1_rd_queue_drained",  64'(rq1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
